// File: rtl/wb_port_arbiter_if.sv
// Register-file write-port arbitration bus.
// master: requester side (drives req, req_addr, stall).
// slave : arbiter side (drives gnt, sel, wr_en, wr_addr, busy).
interface wb_port_arbiter_if;
  logic [7:0]  req;
  logic [39:0] req_addr;
  logic        stall;
  logic [7:0]  gnt;
  logic [2:0]  sel;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic        busy;

  modport master (
    output req, req_addr, stall,
    input  gnt, sel, wr_en, wr_addr, busy
  );

  modport slave (
    input  req, req_addr, stall,
    output gnt, sel, wr_en, wr_addr, busy
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter for an 8-requester register-file write port.
// One-cycle grant latency, one grant per cycle, stall blocks grants.
// The requester granted in the current cycle is masked from the next
// arbitration, so a held req is only re-granted as a new request.
// Compile-time option: define WB_ARB_ZERO_FILTER_EN to suppress wr_en
// for grants whose captured register index is 0 (the grant still issues
// and the pointer still advances).
module wb_port_arbiter (
  input  logic              clk,
  input  logic              reset_n,
  wb_port_arbiter_if.slave  bus
);

`ifdef WB_ARB_ZERO_FILTER_EN
  localparam bit ZERO_FILTER = 1'b1;
`else
  localparam bit ZERO_FILTER = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    STALLED = 2'd2
  } state_t;

  state_t      state;
  logic [2:0]  ptr;

  // Arbitration stage (combinational, from current req and pointer)
  logic [7:0]  elig_p0;
  logic        found_p0;
  logic [2:0]  win_p0;
  logic [4:0]  win_addr_p0;

  // Grant stage (registered outputs)
  logic [7:0]  gnt_p1;
  logic [2:0]  sel_p1;
  logic        wr_en_p1;
  logic [4:0]  wr_addr_p1;

  // Write enable for a winning index; index 0 is dropped when filtering.
  function automatic logic wr_en_for(input logic [4:0] addr);
    return !ZERO_FILTER || (addr != 5'd0);
  endfunction

  // Mask out the requester whose grant pulse is currently on the bus.
  always_comb begin
    elig_p0 = bus.req & ~gnt_p1;
  end

  // Round-robin search: ptr, ptr+1, ... ptr+7 (mod 8); first eligible wins.
  always_comb begin
    found_p0 = 1'b0;
    win_p0   = ptr;
    for (int i = 0; i < 8; i++) begin
      if (!found_p0 && elig_p0[ptr + 3'(i)]) begin
        found_p0 = 1'b1;
        win_p0   = ptr + 3'(i);
      end
    end
  end

  // Capture the winner's register index from its slice of req_addr.
  always_comb begin
    win_addr_p0 = bus.req_addr[5*int'(win_p0) +: 5];
  end

  // Control FSM with registered grant outputs. Every state follows the
  // same rule: stall forces STALLED with no grant, otherwise an eligible
  // requester is granted (GRANT), otherwise IDLE. sel/wr_addr keep their
  // last values whenever no grant is issued.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      ptr        <= 3'd0;
      gnt_p1     <= 8'd0;
      sel_p1     <= 3'd0;
      wr_en_p1   <= 1'b0;
      wr_addr_p1 <= 5'd0;
    end else begin
      gnt_p1   <= 8'd0;
      wr_en_p1 <= 1'b0;
      if (bus.stall) begin
        state <= STALLED;
      end else if (found_p0) begin
        state      <= GRANT;
        gnt_p1     <= 8'b1 << win_p0;
        sel_p1     <= win_p0;
        wr_en_p1   <= wr_en_for(win_addr_p0);
        wr_addr_p1 <= win_addr_p0;
        ptr        <= win_p0 + 3'd1;
      end else begin
        state <= IDLE;
      end
    end
  end

  assign bus.gnt     = gnt_p1;
  assign bus.sel     = sel_p1;
  assign bus.wr_en   = wr_en_p1;
  assign bus.wr_addr = wr_addr_p1;
  assign bus.busy    = (state == GRANT) || (|bus.req);

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed testbench for wb_port_arbiter with a cycle-stamped scoreboard.
// Stimulus pushes the expected grant (cycle, winner, address, wr_en);
// a negedge monitor pops and compares whenever gnt is non-zero.
module tb_wb_port_arbiter;

`ifdef WB_ARB_ZERO_FILTER_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;

  wb_port_arbiter_if bus();

  wb_port_arbiter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    logic [2:0] w;
    logic [4:0] addr;
    logic       wen;
  } exp_t;

  exp_t       sbq[$];
  exp_t       mon_e;
  logic [4:0] addr_tab [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_addrs();
    for (int i = 0; i < 8; i++) bus.req_addr[5*i +: 5] = addr_tab[i];
  endtask

  function automatic logic exp_wen(input logic [4:0] a);
    return !ZF || (a != 5'd0);
  endfunction

  task automatic expect_gnt(input int at, input int w);
    exp_t e;
    e.cyc  = at;
    e.w    = 3'(w);
    e.addr = addr_tab[w];
    e.wen  = exp_wen(addr_tab[w]);
    sbq.push_back(e);
  endtask

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every presented grant against the scoreboard head.
  always @(negedge clk) begin
    if (bus.gnt != 8'h00) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_gnt: got gnt %0h expected none (cycle %0d)", bus.gnt, cyc);
      end else begin
        mon_e = sbq.pop_front();
        check("gnt_cycle", 40'(cyc), 40'(mon_e.cyc));
        check("gnt", 40'(bus.gnt), 40'(8'b1 << mon_e.w));
        check("sel", 40'(bus.sel), 40'(mon_e.w));
        check("wr_en", 40'(bus.wr_en), 40'(mon_e.wen));
        check("wr_addr", 40'(bus.wr_addr), 40'(mon_e.addr));
      end
    end else begin
      check("idle_wr_en", 40'(bus.wr_en), 40'd0);
      if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        mon_e = sbq.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_gnt: got gnt 0 expected requester %0d (cycle %0d)", mon_e.w, cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n   = 1'b0;
    bus.stall = 1'b0;
    bus.req   = 8'hFF;
    addr_tab  = '{5'd9, 5'd10, 5'd12, 5'd17, 5'd20, 5'd22, 5'd25, 5'd31};
    drive_addrs();
    repeat (2) @(posedge clk);
    #1;

    // Reset with all requesters active.
    check("rst_gnt", 40'(bus.gnt), 40'd0);
    check("rst_wr_en", 40'(bus.wr_en), 40'd0);
    check("rst_sel", 40'(bus.sel), 40'd0);
    check("rst_wr_addr", 40'(bus.wr_addr), 40'd0);
    check("rst_busy", 40'(bus.busy), 40'd1);

    // Release with req=FF held: grants 0..7 then 0.
    reset_n = 1'b1;
    for (int k = 0; k < 9; k++) expect_gnt(cyc + 1 + k, k % 8);
    repeat (9) tick();
    bus.req = 8'h00;
    tick();
    check("busy_idle", 40'(bus.busy), 40'd0);

    // Bring ptr to 6 via a grant to 5, then 6 wins, then 0 after wrap.
    bus.req = 8'h20; expect_gnt(cyc + 1, 5); tick();
    bus.req = 8'h41; expect_gnt(cyc + 1, 6); tick();
    bus.req = 8'h01; expect_gnt(cyc + 1, 0); tick();
    bus.req = 8'h00; tick();

    // Requester 3, index 17; other indices scrambled; held req re-granted at t+3.
    for (int i = 0; i < 8; i++) if (i != 3) addr_tab[i] = 5'd0;
    drive_addrs();
    bus.req = 8'h08; expect_gnt(cyc + 1, 3); tick();
    for (int i = 0; i < 8; i++) if (i != 3) addr_tab[i] = 5'h15;
    drive_addrs();
    check("busy_grant", 40'(bus.busy), 40'd1);
    tick();
    check("busy_req_pending", 40'(bus.busy), 40'd1);
    expect_gnt(cyc + 1, 3); tick();
    bus.req  = 8'h00;
    addr_tab = '{5'd9, 5'd10, 5'd12, 5'd17, 5'd20, 5'd22, 5'd25, 5'd31};
    drive_addrs();
    tick();

    // Stall and req rise together; grant one cycle after stall falls.
    bus.stall = 1'b1; bus.req = 8'h04;
    repeat (3) tick();
    check("busy_stalled", 40'(bus.busy), 40'd1);
    bus.stall = 1'b0; expect_gnt(cyc + 1, 2); tick();
    bus.req = 8'h00; tick();

    // Stall during GRANT suppresses the pending grant and holds ptr.
    bus.req = 8'h03; expect_gnt(cyc + 1, 0); tick();
    bus.req = 8'h82; bus.stall = 1'b1; tick();
    bus.stall = 1'b0; expect_gnt(cyc + 1, 1); tick();
    bus.req = 8'h80; expect_gnt(cyc + 1, 7); tick();
    bus.req = 8'h00; tick();

    // Requester 5 with register index 0, then ptr must have advanced to 6.
    addr_tab[5] = 5'd0; drive_addrs();
    bus.req = 8'h20; expect_gnt(cyc + 1, 5); tick();
    bus.req = 8'h00; addr_tab[5] = 5'd22; drive_addrs(); tick();
    bus.req = 8'h41; expect_gnt(cyc + 1, 6); tick();
    bus.req = 8'h00; tick();

    // Reset pulsed during a GRANT cycle.
    bus.req = 8'h10; tick();
    check("mid_gnt", 40'(bus.gnt), 40'h10);
    check("mid_wr_en", 40'(bus.wr_en), 40'd1);
    reset_n = 1'b0; bus.req = 8'h00;
    #1;
    check("rst_mid_gnt", 40'(bus.gnt), 40'd0);
    check("rst_mid_wr_en", 40'(bus.wr_en), 40'd0);
    check("rst_mid_sel", 40'(bus.sel), 40'd0);
    check("rst_mid_wr_addr", 40'(bus.wr_addr), 40'd0);
    check("rst_mid_busy", 40'(bus.busy), 40'd0);
    tick();
    reset_n = 1'b1;
    bus.req = 8'h88; expect_gnt(cyc + 1, 3); tick();
    bus.req = 8'h80; expect_gnt(cyc + 1, 7); tick();
    bus.req = 8'h00;
    repeat (3) tick();

    for (int n = 0; n < 20 && sbq.size() > 0; n++) tick();
    while (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      checks++;
      errors++;
      $display("FAIL leftover_gnt: got none expected requester %0d at cycle %0d", mon_e.w, mon_e.cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
